// File: rtl/attack_scan_if.sv
// Request/result bundle for the attack_scan square-attack scanner.
// Also provides the piece-code macros shared by the scanner and its users.
`ifndef EMPTY_POSN
`define EMPTY_POSN   4'd0
`define WHITE_PAWN   4'd1
`define WHITE_KNIGHT 4'd2
`define WHITE_BISHOP 4'd3
`define WHITE_ROOK   4'd4
`define WHITE_QUEEN  4'd5
`define WHITE_KING   4'd6
`define BLACK_PAWN   4'd9
`define BLACK_KNIGHT 4'd10
`define BLACK_BISHOP 4'd11
`define BLACK_ROOK   4'd12
`define BLACK_QUEEN  4'd13
`define BLACK_KING   4'd14
`endif

interface attack_scan_if #(
    parameter int PIECE_WIDTH = 4,
    parameter int BOARD_WIDTH = PIECE_WIDTH * 64
);
    // Handshake: start is a request that is accepted on a rising clk edge only while busy==0;
    // board/attacker/square_mask are sampled on that edge. done pulses for one cycle when
    // attacked/attacked_mask are valid; they hold until the next accepted start.
    logic [BOARD_WIDTH-1:0] board;
    logic                   attacker;
    logic [63:0]            square_mask;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   attacked;
    logic [63:0]            attacked_mask;
    logic                   scan_state;

    modport master (
        output board, attacker, square_mask, start,
        input  busy, done, attacked, attacked_mask, scan_state
    );

    modport slave (
        input  board, attacker, square_mask, start,
        output busy, done, attacked, attacked_mask, scan_state
    );
endinterface

// File: rtl/attack_scan.sv
// Runtime-addressed square-attack scanner: tests LANES masked squares per cycle against a latched board.
// Optional early exit on first attacked group: define ATTACK_SCAN_EARLY_EXIT_EN.
`ifndef EMPTY_POSN
`define EMPTY_POSN   4'd0
`define WHITE_PAWN   4'd1
`define WHITE_KNIGHT 4'd2
`define WHITE_BISHOP 4'd3
`define WHITE_ROOK   4'd4
`define WHITE_QUEEN  4'd5
`define WHITE_KING   4'd6
`define BLACK_PAWN   4'd9
`define BLACK_KNIGHT 4'd10
`define BLACK_BISHOP 4'd11
`define BLACK_ROOK   4'd12
`define BLACK_QUEEN  4'd13
`define BLACK_KING   4'd14
`endif

module attack_scan #(
    parameter int PIECE_WIDTH = 4,
    parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH = SIDE_WIDTH * 8,
    parameter int LANES       = 8
) (
    input logic          clk,
    input logic          reset,
    attack_scan_if.slave scan_bus
);
    localparam int GROUPS = 64 / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS - 1);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_attacked;
    logic [63:0]            r_attacked_mask;
    logic [GW-1:0]          r_group;
    logic [BOARD_WIDTH-1:0] r_board;
    logic                   r_attacker;
    logic [63:0]            r_mask;

    logic [63:0]            w_group_hits;
    logic [63:0]            w_next_mask;
    logic                   w_stop_early;

    function automatic logic on_board(input int row, input int col);
        return (row >= 0) && (row < 8) && (col >= 0) && (col < 8);
    endfunction

    function automatic logic [PIECE_WIDTH-1:0] piece_at(input logic [BOARD_WIDTH-1:0] b,
                                                        input int row, input int col);
        logic [BOARD_WIDTH-1:0] shifted;
        shifted = b >> ((row * 8 + col) * PIECE_WIDTH);
        return shifted[PIECE_WIDTH-1:0];
    endfunction

    // All offsets are applied in row/col space so nothing wraps across board edges.
    function automatic logic sq_attacked(input logic [BOARD_WIDTH-1:0] b, input logic side,
                                         input int row, input int col);
        logic                   hit;
        logic                   blocked;
        logic [PIECE_WIDTH-1:0] p;
        int                     rr;
        int                     cc;
        hit = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    blocked = 1'b0;
                    for (int k = 1; k < 8; k++) begin
                        rr = row + dr * k;
                        cc = col + dc * k;
                        if (on_board(rr, cc) && !blocked) begin
                            p = piece_at(b, rr, cc);
                            if (p != `EMPTY_POSN) begin
                                blocked = 1'b1;
                                if (p == (side ? `BLACK_QUEEN : `WHITE_QUEEN))
                                    hit = 1'b1;
                                if ((dr == 0 || dc == 0) && p == (side ? `BLACK_ROOK : `WHITE_ROOK))
                                    hit = 1'b1;
                                if ((dr != 0 && dc != 0) && p == (side ? `BLACK_BISHOP : `WHITE_BISHOP))
                                    hit = 1'b1;
                            end
                        end
                    end
                    rr = row + dr;
                    cc = col + dc;
                    if (on_board(rr, cc) && piece_at(b, rr, cc) == (side ? `BLACK_KING : `WHITE_KING))
                        hit = 1'b1;
                end
            end
        end
        for (int dr = -2; dr <= 2; dr++) begin
            for (int dc = -2; dc <= 2; dc++) begin
                rr = row + dr;
                cc = col + dc;
                if ((dr * dr + dc * dc == 5) && on_board(rr, cc) &&
                    piece_at(b, rr, cc) == (side ? `BLACK_KNIGHT : `WHITE_KNIGHT))
                    hit = 1'b1;
            end
        end
        // White pawns attack upward (from row-1), black pawns downward (from row+1).
        rr = side ? row + 1 : row - 1;
        for (int dc = -1; dc <= 1; dc += 2) begin
            cc = col + dc;
            if (on_board(rr, cc) && piece_at(b, rr, cc) == (side ? `BLACK_PAWN : `WHITE_PAWN))
                hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [63:0] group_hits(input logic [BOARD_WIDTH-1:0] b, input logic side,
                                               input logic [63:0] mask, input logic [GW-1:0] group);
        logic [63:0] hits;
        logic [5:0]  sq;
        hits = '0;
        for (int l = 0; l < LANES; l++) begin
            sq = 6'(int'(group) * LANES + l);
            if (mask[sq] && sq_attacked(b, side, int'(sq[5:3]), int'(sq[2:0])))
                hits[sq] = 1'b1;
        end
        return hits;
    endfunction

    always_comb begin
        w_group_hits = group_hits(r_board, r_attacker, r_mask, r_group);
        w_next_mask  = r_attacked_mask | w_group_hits;
    end

`ifdef ATTACK_SCAN_EARLY_EXIT_EN
    assign w_stop_early = r_attacked;
`else
    assign w_stop_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_attacked      <= 1'b0;
            r_attacked_mask <= '0;
            r_group         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (scan_bus.start) begin
                        r_board         <= scan_bus.board;
                        r_attacker      <= scan_bus.attacker;
                        r_mask          <= scan_bus.square_mask;
                        r_attacked_mask <= '0;
                        r_attacked      <= 1'b0;
                        r_busy          <= 1'b1;
                        r_group         <= '0;
                        r_state         <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // An earlier group already hit: finish without folding in another group.
                    if (w_stop_early) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_attacked_mask <= w_next_mask;
                        r_attacked      <= |w_next_mask;
                        r_group         <= r_group + 1'b1;
                        if (r_group == LAST_GROUP) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign scan_bus.busy          = r_busy;
    assign scan_bus.done          = r_done;
    assign scan_bus.attacked      = r_attacked;
    assign scan_bus.attacked_mask = r_attacked_mask;
    assign scan_bus.scan_state    = (r_state == S_SCAN);
endmodule
